// File: rtl/range_counter.sv
// rtl/range_counter.sv - parametrised wrap/saturate up/down counter with load and wrap status
// Optional wrap event counter: define RANGE_COUNTER_WRAP_CNT_EN.
module range_counter #(
  parameter int     WIDTH    = 4,
  parameter longint RST_VAL  = 10,
  parameter longint MIN_VAL  = 0,
  parameter longint MAX_VAL  = 15,
  parameter longint STEP     = 1,
  parameter int     SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             at_limit,
  output logic             wrap,
  output logic [7:0]       wrap_cnt
);

  if (WIDTH < 2 || WIDTH > 32 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
      MAX_VAL > ((longint'(1) << WIDTH) - 1) || RST_VAL < MIN_VAL || RST_VAL > MAX_VAL ||
      STEP < 1 || STEP > (MAX_VAL - MIN_VAL + 1) || (SATURATE != 0 && SATURATE != 1))
  begin : g_bad_params
    $error("range_counter: illegal parameter combination");
  end

  // Two guard bits: one for the carry of q+STEP, one for the sign of q-STEP.
  localparam int XW = WIDTH + 2;

  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  localparam logic signed [XW-1:0] MIN_X  = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] MAX_X  = XW'(MAX_VAL);
  localparam logic signed [XW-1:0] STEP_X = XW'(STEP);

  logic [WIDTH-1:0]     q_q, q_d;
  logic                 wrap_q, wrap_d;
  logic signed [XW-1:0] q_ext, up_sum, dn_diff;

  always_comb begin
    q_ext   = {2'b00, q_q};
    up_sum  = q_ext + STEP_X;
    dn_diff = q_ext - STEP_X;
    q_d     = q_q;
    wrap_d  = 1'b0;
    if (load) begin
      if (load_val < MIN_W)      q_d = MIN_W;
      else if (load_val > MAX_W) q_d = MAX_W;
      else                       q_d = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (up_sum <= MAX_X) begin
          q_d = up_sum[WIDTH-1:0];
        end else if (SATURATE != 0) begin
          q_d    = MAX_W;
          wrap_d = (q_q != MAX_W);
        end else begin
          // MIN + (nxt - MAX - 1) evaluated modulo 2^WIDTH
          q_d    = q_q + STEP_W - MAX_W - ONE_W + MIN_W;
          wrap_d = 1'b1;
        end
      end else begin
        if (dn_diff >= MIN_X) begin
          q_d = dn_diff[WIDTH-1:0];
        end else if (SATURATE != 0) begin
          q_d    = MIN_W;
          wrap_d = (q_q != MIN_W);
        end else begin
          q_d    = MAX_W - MIN_W + q_q - STEP_W + ONE_W;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_W;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign at_limit = up_dn ? (q_q == MAX_W) : (q_q == MIN_W);

`ifdef RANGE_COUNTER_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q, wrap_cnt_d;

  // Counts alongside the wrap flag being registered, sticking at 255.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (load)                                  wrap_cnt_d = 8'd0;
    else if (wrap_d && wrap_cnt_q != 8'd255)   wrap_cnt_d = wrap_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_cnt_q <= 8'd0;
    else     wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  assign wrap_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_range_counter.sv
// tb/tb_range_counter.sv - self-checking bench for range_counter over three parameter sets
module tb_range_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic   en_v [3];
  logic   up_v [3];
  logic   ld_v [3];
  longint lvv  [3];

  logic [3:0] lv0, lv1, q0, q1;
  logic [7:0] lv2, q2, cnt0, cnt1, cnt2;
  logic       al0, al1, al2, w0, w1, w2;

  assign lv0 = 4'(lvv[0]);
  assign lv1 = 4'(lvv[1]);
  assign lv2 = 8'(lvv[2]);

  range_counter u_d0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .up_dn(up_v[0]), .load(ld_v[0]), .load_val(lv0),
    .q(q0), .at_limit(al0), .wrap(w0), .wrap_cnt(cnt0));

  range_counter #(.WIDTH(4), .RST_VAL(10), .MIN_VAL(2), .MAX_VAL(12), .STEP(3), .SATURATE(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .up_dn(up_v[1]), .load(ld_v[1]), .load_val(lv1),
    .q(q1), .at_limit(al1), .wrap(w1), .wrap_cnt(cnt1));

  range_counter #(.WIDTH(8), .RST_VAL(100), .MIN_VAL(5), .MAX_VAL(200), .STEP(7), .SATURATE(0)) u_d2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .up_dn(up_v[2]), .load(ld_v[2]), .load_val(lv2),
    .q(q2), .at_limit(al2), .wrap(w2), .wrap_cnt(cnt2));

  int     p_width [3] = '{4, 4, 8};
  longint p_rst   [3] = '{10, 10, 100};
  longint p_min   [3] = '{0, 2, 5};
  longint p_max   [3] = '{15, 12, 200};
  longint p_step  [3] = '{1, 3, 7};
  bit     p_sat   [3] = '{1'b0, 1'b1, 1'b0};

  longint m_q [3];
  bit     m_w [3];
  int     m_c [3];

  logic [63:0] obs_q [3];
  logic        obs_w [3];
  logic        obs_al [3];
  logic [7:0]  obs_c [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_q[k] = p_rst[k];
      m_w[k] = 1'b0;
      m_c[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    longint cur = m_q[k];
    longint n;
    bit     w = 1'b0;
    if (ld_v[k]) begin
      n = lvv[k];
      if (n < p_min[k]) n = p_min[k];
      else if (n > p_max[k]) n = p_max[k];
      m_c[k] = 0;
    end else if (en_v[k]) begin
      if (up_v[k]) begin
        n = cur + p_step[k];
        if (n > p_max[k]) begin
          if (p_sat[k]) begin w = (cur != p_max[k]); n = p_max[k]; end
          else begin n = p_min[k] + (n - p_max[k] - 1); w = 1'b1; end
        end
      end else begin
        n = cur - p_step[k];
        if (n < p_min[k]) begin
          if (p_sat[k]) begin w = (cur != p_min[k]); n = p_min[k]; end
          else begin n = p_max[k] - (p_min[k] - n - 1); w = 1'b1; end
        end
      end
    end else begin
      n = cur;
    end
`ifdef RANGE_COUNTER_WRAP_CNT_EN
    if (!ld_v[k] && w && m_c[k] < 255) m_c[k]++;
`endif
    m_q[k] = n;
    m_w[k] = w;
  endtask

  task automatic sample();
    obs_q[0] = 64'(q0);  obs_q[1] = 64'(q1);  obs_q[2] = 64'(q2);
    obs_w[0] = w0;       obs_w[1] = w1;       obs_w[2] = w2;
    obs_al[0] = al0;     obs_al[1] = al1;     obs_al[2] = al2;
    obs_c[0] = cnt0;     obs_c[1] = cnt1;     obs_c[2] = cnt2;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
    sample();
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      en_v[k] = 1'b0; up_v[k] = 1'b1; ld_v[k] = 1'b0; lvv[k] = 0;
    end
  endtask

  task automatic test_reset();
    idle_all();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 sample();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs_q[k] !== 64'(p_rst[k]) || obs_w[k] !== 1'b0 || obs_c[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: q=%0d wrap=%b cnt=%0d, required q=%0d wrap=0 cnt=0",
                 k, obs_q[k], obs_w[k], obs_c[k], p_rst[k]);
      end
    end
    #1 rst = 1'b0;
    #1 sample();
    n_checks++;
    if (obs_q[0] !== 64'd10) begin
      n_fail++;
      $display("FAIL reset_release: q=%0d, required 10", obs_q[0]);
    end
  endtask

  task automatic test_count_up_wrap();
    int exp_q [6] = '{11, 12, 13, 14, 15, 0};
    en_v[0] = 1'b1; up_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (obs_q[0] !== 64'(exp_q[i]) || obs_w[0] !== (i == 5)) begin
        n_fail++;
        $display("FAIL count_up step %0d: q=%0d wrap=%b, required q=%0d wrap=%b",
                 i, obs_q[0], obs_w[0], exp_q[i], (i == 5));
      end
    end
    en_v[0] = 1'b0;
  endtask

  task automatic test_load_down();
    int exp_q [4] = '{2, 1, 0, 15};
    ld_v[0] = 1'b1; lvv[0] = 3; en_v[0] = 1'b1; up_v[0] = 1'b1;
    tick();
    n_checks++;
    if (obs_q[0] !== 64'd3 || obs_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL load_with_en: q=%0d wrap=%b, required q=3 wrap=0", obs_q[0], obs_w[0]);
    end
    ld_v[0] = 1'b0; up_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs_q[0] !== 64'(exp_q[i]) || obs_w[0] !== (i == 3)) begin
        n_fail++;
        $display("FAIL count_down step %0d: q=%0d wrap=%b, required q=%0d wrap=%b",
                 i, obs_q[0], obs_w[0], exp_q[i], (i == 3));
      end
      if (i == 2) begin
        n_checks++;
        if (obs_al[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL at_limit_min: at_limit=%b, required 1", obs_al[0]);
        end
      end
    end
    en_v[0] = 1'b0;
    up_v[0] = 1'b1;
    #1;
    n_checks++;
    if (al0 !== 1'b1) begin
      n_fail++;
      $display("FAIL at_limit_comb: at_limit=%b with q=15 up_dn=1, required 1", al0);
    end
  endtask

  task automatic test_saturate();
    int exp_q [7] = '{12, 12, 9, 6, 3, 2, 2};
    bit exp_w [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en_v[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      up_v[1] = (i < 2);
      tick();
      n_checks++;
      if (obs_q[1] !== 64'(exp_q[i]) || obs_w[1] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL saturate step %0d: q=%0d wrap=%b, required q=%0d wrap=%b",
                 i, obs_q[1], obs_w[1], exp_q[i], exp_w[i]);
      end
    end
    en_v[1] = 1'b0;
  endtask

  task automatic test_wide_clamp();
    longint lv_tab [3] = '{250, 1, 198};
    longint exp_q  [3] = '{200, 5, 198};
    ld_v[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lvv[2] = lv_tab[i];
      tick();
      n_checks++;
      if (obs_q[2] !== 64'(exp_q[i]) || obs_w[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL wide_load %0d: q=%0d wrap=%b, required q=%0d wrap=0",
                 lv_tab[i], obs_q[2], obs_w[2], exp_q[i]);
      end
    end
    ld_v[2] = 1'b0; en_v[2] = 1'b1; up_v[2] = 1'b1;
    tick();
    n_checks++;
    if (obs_q[2] !== 64'd9 || obs_w[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_wrap: q=%0d wrap=%b, required q=9 wrap=1", obs_q[2], obs_w[2]);
    end
    en_v[2] = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    test_reset();
    en_v[0] = 1'b1; up_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (obs_q[0] !== 64'd13) begin
      n_fail++;
      $display("FAIL pre_reset_count: q=%0d, required 13", obs_q[0]);
    end
    #2 rst = 1'b1;
    model_reset();
    #1 sample();
    n_checks++;
    if (obs_q[0] !== 64'd10 || obs_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_count: q=%0d wrap=%b, required q=10 wrap=0", obs_q[0], obs_w[0]);
    end
    #1 rst = 1'b0;
    en_v[0] = 1'b0;
  endtask

  task automatic test_wrap_cnt();
`ifdef RANGE_COUNTER_WRAP_CNT_EN
    logic [7:0] exp_final = 8'd3;
`else
    logic [7:0] exp_final = 8'd0;
`endif
    test_reset();
    en_v[0] = 1'b1; up_v[0] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      n_checks++;
      if (obs_c[0] !== 8'(m_c[0])) begin
        n_fail++;
        $display("FAIL wrap_cnt cycle %0d: wrap_cnt=%0d, required %0d", i, obs_c[0], m_c[0]);
      end
    end
    n_checks++;
    if (obs_c[0] !== exp_final) begin
      n_fail++;
      $display("FAIL wrap_cnt_48: wrap_cnt=%0d, required %0d", obs_c[0], exp_final);
    end
    ld_v[0] = 1'b1; lvv[0] = 5;
    tick();
    n_checks++;
    if (obs_c[0] !== 8'd0 || obs_q[0] !== 64'd5) begin
      n_fail++;
      $display("FAIL wrap_cnt_load: wrap_cnt=%0d q=%0d, required wrap_cnt=0 q=5", obs_c[0], obs_q[0]);
    end
    idle_all();
  endtask

  task automatic test_random();
    bit exp_al;
    test_reset();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        ld_v[k] = ($urandom_range(0, 9) == 0);
        en_v[k] = ($urandom_range(0, 3) != 0);
        up_v[k] = ($urandom_range(0, 2) != 0);
        lvv[k]  = longint'($urandom_range(0, (1 << p_width[k]) - 1));
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        exp_al = up_v[k] ? (m_q[k] == p_max[k]) : (m_q[k] == p_min[k]);
        n_checks++;
        if (obs_q[k] !== 64'(m_q[k]) || obs_w[k] !== m_w[k] ||
            obs_c[k] !== 8'(m_c[k]) || obs_al[k] !== exp_al) begin
          n_fail++;
          $display("FAIL random dut%0d cycle %0d: q=%0d wrap=%b cnt=%0d at_limit=%b, required q=%0d wrap=%b cnt=%0d at_limit=%b",
                   k, c, obs_q[k], obs_w[k], obs_c[k], obs_al[k], m_q[k], m_w[k], m_c[k], exp_al);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    model_reset();
    test_reset();
    test_count_up_wrap();
    test_load_down();
    test_saturate();
    test_wide_clamp();
    test_reset_mid_count();
    test_wrap_cnt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/range_counter.md
Name: range_counter

Overview:
- Parametrised up/down counter for the level-2 counter family, replacing fixed-width, fixed-reset-value counters such as a 4-bit counter that restarts at 10.
- Supports configurable width, reset value, inclusive range [MIN_VAL, MAX_VAL], step size, wrap or saturate mode, synchronous load, and boundary/wrap status.
- Used as the base counter for timers, dividers and sequencers in later training levels.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- RST_VAL, 10: value of q after reset; must satisfy MIN_VAL <= RST_VAL <= MAX_VAL.
- MIN_VAL, 0: lower bound, inclusive.
- MAX_VAL, 15: upper bound, inclusive; must satisfy MIN_VAL < MAX_VAL <= 2^WIDTH-1.
- STEP, 1: increment/decrement per enabled cycle; legal range 1..(MAX_VAL-MIN_VAL+1).
- SATURATE, 0: 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, registered.
- at_limit  output  1  combinational: (up_dn & q==MAX_VAL) | (~up_dn & q==MIN_VAL).
- wrap  output  1  registered one-cycle pulse: the previous update crossed or hit a bound.
- wrap_cnt  output  8  number of wrap events (see Optional Feature).

Behaviour:
- Reset (asynchronous): q=RST_VAL, wrap=0, wrap_cnt=0. Reset asserted mid-count takes effect immediately, without waiting for clk. The first update happens on the first rising edge after rst deasserts.
- Priority each cycle: load > en > hold.
- Load:
  - q <= load_val clamped into [MIN_VAL, MAX_VAL]; below MIN_VAL gives MIN_VAL, above MAX_VAL gives MAX_VAL.
  - wrap <= 0 and wrap_cnt <= 0. Load with en=1 ignores en.
- Count up (en=1, up_dn=1), with nxt = q+STEP computed in WIDTH+1 bits so no carry is lost:
  - nxt <= MAX_VAL: q <= nxt, wrap <= 0.
  - nxt > MAX_VAL, SATURATE=0: q <= MIN_VAL + (nxt-MAX_VAL-1), wrap <= 1.
  - nxt > MAX_VAL, SATURATE=1: q <= MAX_VAL, wrap <= 1 only if q was not already MAX_VAL.
- Count down (en=1, up_dn=0), with nxt = q-STEP computed in signed WIDTH+1 bits:
  - nxt >= MIN_VAL: q <= nxt, wrap <= 0.
  - nxt < MIN_VAL, SATURATE=0: q <= MAX_VAL - (MIN_VAL-nxt-1), wrap <= 1.
  - nxt < MIN_VAL, SATURATE=1: q <= MIN_VAL, wrap <= 1 only if q was not already MIN_VAL.
- Hold (en=0, load=0): q unchanged, wrap <= 0.
- Latency:
  - q reflects load or count one clock after the strobe.
  - wrap is high in the same cycle the post-wrap q is visible.
  - at_limit has zero latency and follows up_dn combinationally.
- Direction change: takes effect on the next enabled edge, with no extra cycle.
- If q is somehow outside [MIN_VAL, MAX_VAL], the next count treats it per the arithmetic rules above. This cannot happen through legal ports.
- Parameter checks: illegal parameter combinations stop elaboration via a generate-time check.

Optional Feature:
- Macro: RANGE_COUNTER_WRAP_CNT_EN.
- Defined:
  - wrap_cnt increments on every cycle in which wrap is set.
  - It saturates at 255 and is cleared by reset or load.
- Undefined:
  - wrap_cnt is tied to 8'd0 and no counter register is built.
  - The port list is unchanged.

Test Plan:
- Defaults: assert rst asynchronously between edges, then release -> q=10 immediately and at release; en=1, up_dn=1 for 6 cycles -> q=11,12,13,14,15,0, with wrap=1 only in the cycle q=0.
- Defaults: load=1, load_val=3 with en=1 -> q=3 next cycle, wrap=0; then up_dn=0, en=1 for 4 cycles -> q=2,1,0,15 with wrap at 15; at_limit=1 while q=0 and up_dn=0.
- SATURATE=1, MIN_VAL=2, MAX_VAL=12, STEP=3, RST_VAL=10: count up -> q=12 (wrap=1), 12 (wrap=0); count down -> 9,6,3,2 (wrap=1), 2 (wrap=0).
- WIDTH=8, MIN_VAL=5, MAX_VAL=200, STEP=7: load_val=250 -> q=200; load_val=1 -> q=5; count up from 198 -> q=5+(205-201)=9, wrap=1.
- Defaults: assert rst mid-count at q=13, between edges -> q=10 before the next edge; wrap=0.
- With RANGE_COUNTER_WRAP_CNT_EN defined, defaults: run 48 up-cycles from reset -> wrap_cnt=3; then load -> wrap_cnt=0. Without the macro -> wrap_cnt stays 0 throughout.
